// File: rtl/unsigned_div.sv
// Sequential restoring divider: DIVIDEND_W-bit dividend by DIVISOR_W-bit divisor,
// one shift-subtract step per clock under a start/done handshake.
module unsigned_div #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend_in,
  input  logic [DIVISOR_W-1:0]  divisor_in,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient_out,
  output logic [DIVISOR_W-1:0]  remainder_out,
  output logic                  div_by_zero
);

  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t                state_r, state_s;
  logic [CNT_W-1:0]      cnt_r, cnt_s;
  logic [DIVISOR_W:0]    part_r, part_s;
  logic [DIVIDEND_W-1:0] q_r, q_s;
  logic [DIVISOR_W-1:0]  dvs_r, dvs_s;
  logic                  busy_s, done_s, dbz_s;
  logic [DIVIDEND_W-1:0] quo_s;
  logic [DIVISOR_W-1:0]  rem_s;
  logic [DIVISOR_W:0]    shifted_s, diff_s;
  logic                  fits_s;

  // One restoring step; the compare is kept at full DIVISOR_W+1 width
  always_comb begin
    shifted_s = {part_r[DIVISOR_W-1:0], q_r[DIVIDEND_W-1]};
    diff_s    = shifted_s - {1'b0, dvs_r};
    fits_s    = (shifted_s >= {1'b0, dvs_r});
  end

  // Next-state and registered-output logic
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    part_s  = part_r;
    q_s     = q_r;
    dvs_s   = dvs_r;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    quo_s   = quotient_out;
    rem_s   = remainder_out;
    dbz_s   = div_by_zero;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (divisor_in != '0) begin
            state_s = CALC;
            cnt_s   = '0;
            part_s  = '0;
            q_s     = dividend_in;
            dvs_s   = divisor_in;
            busy_s  = 1'b1;
          end else begin
            quo_s  = '1;
            rem_s  = '0;
            dbz_s  = 1'b1;
            done_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        part_s = fits_s ? diff_s : shifted_s;
        q_s    = (q_r << 1) | DIVIDEND_W'(fits_s);
        if (cnt_r == CNT_LAST) begin
          state_s = IDLE;
          done_s  = 1'b1;
          quo_s   = q_s;
          rem_s   = part_s[DIVISOR_W-1:0];
          dbz_s   = 1'b0;
        end else begin
          cnt_s  = cnt_r + CNT_W'(1);
          busy_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      part_r        <= '0;
      q_r           <= '0;
      dvs_r         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      quotient_out  <= '0;
      remainder_out <= '0;
      div_by_zero   <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      part_r        <= part_s;
      q_r           <= q_s;
      dvs_r         <= dvs_s;
      busy          <= busy_s;
      done          <= done_s;
      quotient_out  <= quo_s;
      remainder_out <= rem_s;
      div_by_zero   <= dbz_s;
    end
  end

endmodule

// File: tb/tb_unsigned_div.sv
// Directed self-checking bench for unsigned_div (8-bit / 4-bit).
module tb_unsigned_div;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend_in;
  logic [3:0] divisor_in;
  logic       busy;
  logic       done;
  logic [7:0] quotient_out;
  logic [3:0] remainder_out;
  logic       div_by_zero;

  int tests;
  int fails;

  unsigned_div #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dividend_in(dividend_in), .divisor_in(divisor_in),
    .busy(busy), .done(done), .quotient_out(quotient_out),
    .remainder_out(remainder_out), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits (bounded) for done after start was raised at a falling edge.
  // edges = rising edges after the accepting edge until done was registered.
  task automatic wait_done(output int edges, output int busy_cnt, output bit got);
    got = 1'b0; edges = -1; busy_cnt = 0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        got = 1'b1;
        edges = k - 1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; dividend_in = 8'd0; divisor_in = 4'd0;
    #2 rst_n = 1'b0;
    #4;
    tests++;
    if ({busy, done, quotient_out, remainder_out, div_by_zero} !== 15'd0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0",
               busy, done, quotient_out, remainder_out, div_by_zero);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] va [5] = '{8'd200, 8'd255, 8'd255, 8'd9, 8'd0};
    logic [3:0] vd [5] = '{4'd7, 4'd1, 4'd15, 4'd15, 4'd5};
    logic [7:0] vq [5] = '{8'd28, 8'd255, 8'd17, 8'd0, 8'd0};
    logic [3:0] vr [5] = '{4'd4, 4'd0, 4'd0, 4'd9, 4'd0};
    int edges, bcnt;
    bit got;
    for (int i = 0; i < 5; i++) begin
      dividend_in = va[i]; divisor_in = vd[i]; start = 1'b1;
      wait_done(edges, bcnt, got);
      tests++;
      if (!got || edges != 8 || bcnt != 8) begin
        fails++;
        $display("FAIL basic_timing %0d/%0d: got done=%b edges=%0d busy=%0d, want edges=8 busy=8",
                 va[i], vd[i], got, edges, bcnt);
      end
      tests++;
      if (quotient_out !== vq[i] || remainder_out !== vr[i] || div_by_zero !== 1'b0) begin
        fails++;
        $display("FAIL basic_result %0d/%0d: got %0d r %0d dbz=%b, want %0d r %0d dbz=0",
                 va[i], vd[i], quotient_out, remainder_out, div_by_zero, vq[i], vr[i]);
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL done_one_cycle: got done=%b busy=%b, want 0 0", done, busy);
      end
    end
  endtask

  task automatic test_div_zero();
    int edges, bcnt;
    bit got;
    dividend_in = 8'd100; divisor_in = 4'd0; start = 1'b1;
    wait_done(edges, bcnt, got);
    tests++;
    if (!got || edges != 0 || bcnt != 0) begin
      fails++;
      $display("FAIL dbz_timing: got done=%b edges=%0d busy=%0d, want edges=0 busy=0",
               got, edges, bcnt);
    end
    tests++;
    if (quotient_out !== 8'hFF || remainder_out !== 4'd0 || div_by_zero !== 1'b1) begin
      fails++;
      $display("FAIL dbz_result: got q=%0h r=%0d dbz=%b, want ff 0 1",
               quotient_out, remainder_out, div_by_zero);
    end
    @(negedge clk);
    dividend_in = 8'd100; divisor_in = 4'd10; start = 1'b1;
    wait_done(edges, bcnt, got);
    tests++;
    if (!got || quotient_out !== 8'd10 || remainder_out !== 4'd0 || div_by_zero !== 1'b0) begin
      fails++;
      $display("FAIL dbz_clear: got done=%b %0d r %0d dbz=%b, want 10 r 0 dbz=0",
               got, quotient_out, remainder_out, div_by_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int edges, bcnt, ndone;
    bit got;
    dividend_in = 8'd200; divisor_in = 4'd7; start = 1'b1;
    got = 1'b0; edges = -1; ndone = 0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        got = 1'b1;
        edges = k - 1;
      end
      if (k == 3) begin
        start = 1'b1; dividend_in = 8'd50; divisor_in = 4'd3;
      end
      if (k == 5) begin
        dividend_in = 8'd99; divisor_in = 4'd9;
      end
    end
    tests++;
    if (!got || edges != 8 || quotient_out !== 8'd28 || remainder_out !== 4'd4) begin
      fails++;
      $display("FAIL ignore_busy_start: got done=%b edges=%0d %0d r %0d, want edges=8 28 r 4",
               got, edges, quotient_out, remainder_out);
    end
    dividend_in = 8'd50; divisor_in = 4'd3; start = 1'b1;
    wait_done(edges, bcnt, got);
    tests++;
    if (!got || edges != 8 || quotient_out !== 8'd16 || remainder_out !== 4'd2) begin
      fails++;
      $display("FAIL back_to_back: got done=%b edges=%0d %0d r %0d, want edges=8 16 r 2",
               got, edges, quotient_out, remainder_out);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    tests++;
    if (ndone != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL not_queued: got extra done=%0d busy=%b, want 0 0", ndone, busy);
    end
  endtask

  task automatic test_reset_mid();
    int edges, bcnt, ndone;
    bit got;
    dividend_in = 8'd200; divisor_in = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, quotient_out, remainder_out, div_by_zero} !== 15'd0) begin
      fails++;
      $display("FAIL reset_mid: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0",
               busy, done, quotient_out, remainder_out, div_by_zero);
    end
    ndone = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    tests++;
    if (ndone != 0) begin
      fails++;
      $display("FAIL reset_abort: got %0d cycles with done/busy after abort, want 0", ndone);
    end
    dividend_in = 8'd77; divisor_in = 4'd6; start = 1'b1;
    wait_done(edges, bcnt, got);
    tests++;
    if (!got || edges != 8 || quotient_out !== 8'd12 || remainder_out !== 4'd5) begin
      fails++;
      $display("FAIL after_reset: got done=%b edges=%0d %0d r %0d, want edges=8 12 r 5",
               got, edges, quotient_out, remainder_out);
    end
    @(negedge clk);
  endtask

  task automatic test_hold_start();
    int pulses, last;
    dividend_in = 8'd13; divisor_in = 4'd4; start = 1'b1;
    pulses = 0; last = 0;
    for (int k = 1; k <= 60 && pulses < 4; k++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (pulses > 1) begin
          tests++;
          if (k - last != 9) begin
            fails++;
            $display("FAIL hold_period: got %0d cycles between done, want 9", k - last);
          end
        end
        last = k;
      end
      if (pulses >= 1) begin
        tests++;
        if (quotient_out !== 8'd3 || remainder_out !== 4'd1 || div_by_zero !== 1'b0) begin
          fails++;
          $display("FAIL hold_result: got %0d r %0d dbz=%b, want 3 r 1 dbz=0",
                   quotient_out, remainder_out, div_by_zero);
        end
      end
    end
    start = 1'b0;
    tests++;
    if (pulses != 4) begin
      fails++;
      $display("FAIL hold_pulses: got %0d done pulses, want 4", pulses);
    end
    @(negedge clk);
  endtask

  task automatic test_sweep();
    int edges, bcnt;
    bit got;
    for (int a = 0; a < 256; a++) begin
      for (int d = 1; d < 16; d++) begin
        dividend_in = 8'(a); divisor_in = 4'(d); start = 1'b1;
        wait_done(edges, bcnt, got);
        tests++;
        if (!got || (int'(quotient_out) * d + int'(remainder_out)) != a ||
            int'(remainder_out) >= d || div_by_zero !== 1'b0) begin
          fails++;
          $display("FAIL sweep %0d/%0d: got done=%b %0d r %0d dbz=%b, want q*d+r=%0d r<%0d",
                   a, d, got, quotient_out, remainder_out, div_by_zero, a, d);
        end
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_hold_start();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/unsigned_div.md
# unsigned_div

Sequential unsigned restoring divider: the inverse of the team's 4x4 array multiplier. Divides an 8-bit dividend by a 4-bit divisor, yielding an 8-bit quotient and a 4-bit remainder. Uses one shift-subtract iteration per clock under a start/done handshake. Sits beside the multiplier in the arithmetic datapath, so multiply/divide round-trips can be checked (a*b / b == a, remainder 0 for b != 0).

## Interface
- `DIVIDEND_W`, default 8: dividend and quotient width; also the iteration count.
- `DIVISOR_W`, default 4: divisor and remainder width.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: request; sampled only while `busy`=0.
- `dividend_in`  in  DIVIDEND_W: dividend; sampled with an accepted `start`.
- `divisor_in`  in  DIVISOR_W: divisor; sampled with an accepted `start`.
- `busy`  out  1: high while an operation is in progress.
- `done`  out  1: one-cycle pulse when the result outputs are updated.
- `quotient_out`  out  DIVIDEND_W: quotient; held until the next `done`.
- `remainder_out`  out  DIVISOR_W: remainder; held until the next `done`.
- `div_by_zero`  out  1: flag for the last result; valid with `done` and held with the results.

## Operation
- States:
  - IDLE: `busy`=0.
  - CALC: `busy`=1, iteration counter 0..DIVIDEND_W-1.
- Reset (async, any state): state IDLE; all outputs 0 (`busy`, `done`, `quotient_out`, `remainder_out`, `div_by_zero`); internal registers cleared.
- Acceptance: in IDLE with `start`=1, latch the operands.
  - If divisor != 0: go to CALC, counter=0, partial remainder R (DIVISOR_W+1 bits)=0, shift register Q=dividend.
  - If divisor == 0: stay in IDLE. On that edge, register `quotient_out`=all ones (0xFF), `remainder_out`=0, `div_by_zero`=1, and pulse `done`.
- Each CALC cycle:
  - R' = {R[DIVISOR_W-1:0], Q[MSB]}; Q shifts left by one.
  - If R' >= divisor: R = R' - divisor and Q[0]=1. Otherwise R = R' and Q[0]=0.
  - The comparison is unsigned at DIVISOR_W+1 bits, with no truncation before the compare.
- On the last iteration (counter = DIVIDEND_W-1):
  - Register `quotient_out`=final Q, `remainder_out`=final R[DIVISOR_W-1:0], `div_by_zero`=0, and pulse `done`.
  - Return to IDLE.
- Invariant for divisor d != 0: quotient*d + remainder == dividend, and remainder < d.
- `start` while `busy`=1 is ignored. It is not queued. Operand changes during CALC have no effect.
- `quotient_out`, `remainder_out` and `div_by_zero` change only on a `done` edge or on reset.

## Timing
- Call the accepting edge T0.
- Normal divide:
  - `busy` is high from after T0 through the cycle before T0+DIVIDEND_W.
  - At T0+DIVIDEND_W (8 for the default), results update, `done`=1 and `busy`=0.
  - `done` stays high for exactly one cycle.
- Divide by zero: results update at T0, `done` is high for the cycle after T0, and `busy` never rises.
- Back-to-back: `start` may be asserted during the `done` cycle, because `busy`=0 then. It is accepted at the next edge, giving a throughput of one result per DIVIDEND_W+1 cycles.
- `start` held high continuously starts a new operation every time the block returns to IDLE.
- Reset asserted mid-CALC aborts the operation immediately. No `done` is produced, and the outputs read 0 while `rst_n`=0. The first `start` after `rst_n` rises is accepted normally.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- 200/7 -> `done` 8 cycles after the accepting edge; `quotient_out`=28, `remainder_out`=4, `div_by_zero`=0; `busy` high for exactly 8 cycles.
- 255/1 -> 255 r 0; 255/15 -> 17 r 0; 9/15 -> 0 r 9; 0/5 -> 0 r 0. Also an exhaustive sweep of all 256x15 nonzero pairs, checking q*d+r == dividend and r < d against the multiplier model.
- 100/0 -> `done` 1 cycle after acceptance, `quotient_out`=0xFF, `remainder_out`=0, `div_by_zero`=1, `busy` never high. A following 100/10 clears the flag, giving 10 r 0.
- Pulse `start` with 50/3 while busy computing 200/7 -> the second request is ignored and the only result is 28 r 4. Then start 50/3 in the `done` cycle -> accepted, result 16 r 2 eight cycles later.
- Drop `rst_n` at cycle 4 of a 200/7 divide -> all outputs 0 immediately and no `done`. After release, 77/6 -> 12 r 5.
- Hold `start`=1 with constant operands 13/4 -> `done` every 9 cycles with 3 r 1; results stable between pulses.
